// File: rtl/bit_packer_pkg.sv
// Shared types and width helpers for the bit packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_packer_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Width of a chunk length field able to hold 0..in_w.
  function automatic int len_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  // Width of a byte count able to hold 0..out_w/8.
  function automatic int bytes_w(input int out_w);
    return $clog2(out_w / 8 + 1);
  endfunction

  // Width of the externally visible occupancy counter.
  function automatic int occ_w(input int out_w);
    return $clog2(2 * out_w);
  endfunction

  // Internal fill counter width: must also hold exactly 2*out_w after pad rounding.
  function automatic int cnt_w(input int out_w);
    return $clog2(2 * out_w + 1);
  endfunction

endpackage

// File: rtl/bit_packer_shl.sv
// Masks a chunk to its valid length and shifts it to its accumulator position.
// Latency: combinational.
// Backpressure: none, pure datapath.
module bit_packer_shl
  import bit_packer_pkg::*;
#(
  parameter  int IN_W  = 256,
  parameter  int OUT_W = 256,
  localparam int LEN_W = len_w(IN_W),
  localparam int CNT_W = cnt_w(OUT_W)
) (
  input  logic [IN_W-1:0]    data,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   sh,
  output logic [2*OUT_W-1:0] bits
);

  logic [IN_W-1:0]    mask;
  logic [2*OUT_W-1:0] wide;

  // Clear bits at or above len (len == IN_W shifts every one out, keeping all), then place at sh.
  always_comb begin
    mask             = ~({IN_W{1'b1}} << len);
    wide             = '0;
    wide[IN_W-1:0]   = data & mask;
    bits             = wide << sh;
  end

endmodule

// File: rtl/bit_packer.sv
// Packs variable-length LSB-first bit chunks into OUT_W-bit words, byte-aligning and flushing on in_last.
// Latency: 1 cycle from the accept that completes a word to out_valid when the output slot is free.
// Backpressure: output register holds while out_valid && !out_ready; in_ready drops once a full word is stuck or during flush.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter  int IN_W    = 256,
  parameter  int OUT_W   = 256,
  localparam int LEN_W   = len_w(IN_W),
  localparam int BYTES_W = bytes_w(OUT_W),
  localparam int OCC_W   = occ_w(OUT_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [BYTES_W-1:0] out_bytes,
  output logic               out_last,
  output logic [OCC_W-1:0]   fill_bits,
  output logic               len_err
);

  localparam int                 CNT_W      = cnt_w(OUT_W);
  localparam int                 ACC_W      = 2 * OUT_W;
  localparam logic [CNT_W-1:0]   WORD_BITS  = CNT_W'(OUT_W);
  localparam logic [BYTES_W-1:0] WORD_BYTES = BYTES_W'(OUT_W / 8);
  localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(IN_W);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   fill_q, fill_d;

  logic               slot_free, drain_cur, drain_mrg, accept, len_big;
  logic [LEN_W-1:0]   len_c;
  logic [ACC_W-1:0]   base_acc, mrg_acc, shl_bits;
  logic [CNT_W-1:0]   base_fill, mrg_fill, tail;
  logic               emit, emit_last;
  logic [OUT_W-1:0]   emit_data;
  logic [BYTES_W-1:0] emit_bytes;

  bit_packer_shl #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_shl (
    .data (in_data),
    .len  (len_c),
    .sh   (base_fill),
    .bits (shl_bits)
  );

  // Handshake, pre-accept drain of an already full word, and merge of the accepted chunk.
  always_comb begin
    slot_free = !out_valid || out_ready;
    drain_cur = (fill_q >= WORD_BITS) && slot_free;
    in_ready  = (state_q == RUN) && ((fill_q < WORD_BITS) || drain_cur);
    accept    = in_valid && in_ready;
    len_big   = in_len > MAX_LEN;
    len_c     = len_big ? MAX_LEN : in_len;
    base_acc  = drain_cur ? (acc_q >> OUT_W) : acc_q;
    base_fill = drain_cur ? (fill_q - WORD_BITS) : fill_q;
    mrg_acc   = accept ? (base_acc | shl_bits) : base_acc;
    mrg_fill  = accept ? (base_fill + CNT_W'(len_c)) : base_fill;
    // A word completed by this very beat leaves at once, giving single-cycle latency.
    drain_mrg = !drain_cur && slot_free && (mrg_fill >= WORD_BITS);
  end

  // Next accumulator/fill/state and the word (if any) loaded into the output register.
  always_comb begin
    state_d    = state_q;
    acc_d      = mrg_acc;
    fill_d     = mrg_fill;
    tail       = '0;
    emit       = 1'b0;
    emit_data  = acc_q[OUT_W-1:0];
    emit_bytes = WORD_BYTES;
    emit_last  = 1'b0;

    if (drain_cur) begin
      emit = 1'b1;
    end else if (drain_mrg) begin
      emit      = 1'b1;
      emit_data = mrg_acc[OUT_W-1:0];
      acc_d     = mrg_acc >> OUT_W;
      fill_d    = mrg_fill - WORD_BITS;
    end

    if (state_q == RUN) begin
      if (accept && in_last) begin
        if (emit && fill_d == '0) begin
          // Block ended exactly on a word boundary: the outgoing word closes it.
          emit_last = 1'b1;
        end else begin
          // Bits above fill are always zero, so rounding up inserts zero pad bits.
          tail    = fill_d;
          fill_d  = (tail + CNT_W'(7)) & ~CNT_W'(7);
          state_d = FLUSH;
        end
      end
    end else if (drain_cur) begin
      if (fill_d == '0) begin
        emit_last = 1'b1;
        state_d   = RUN;
      end
    end else if (slot_free) begin
      // Partial (or empty) tail word; fill is a multiple of 8 here.
      emit       = 1'b1;
      emit_data  = acc_q[OUT_W-1:0];
      emit_bytes = BYTES_W'(fill_q >> 3);
      emit_last  = 1'b1;
      acc_d      = '0;
      fill_d     = '0;
      state_d    = RUN;
    end
  end

  // State, accumulator, sticky error and the registered output slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RUN;
      acc_q     <= '0;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      out_last  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      if (accept && len_big) begin
        len_err <= 1'b1;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_data;
        out_bytes <= emit_bytes;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign fill_bits = fill_q[OCC_W-1:0];

endmodule

// File: tb/tb_bit_packer.sv
// Directed self-checking bench for bit_packer with IN_W=32, OUT_W=64.
// Latency: checks single-cycle word latency and flush timing.
// Backpressure: exercises a stalled output slot with a full accumulator.
module tb_bit_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [3:0]  out_bytes;
  logic [6:0]  fill_bits;
  logic        len_err;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  logic [63:0] q_data[$];
  logic [3:0]  q_bytes[$];
  logic        q_last[$];

  always #5 clk = ~clk;

  bit_packer #(.IN_W(32), .OUT_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .fill_bits (fill_bits),
    .len_err   (len_err)
  );

  // Output word collector and input stall counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bytes.push_back(out_bytes);
      q_last.push_back(out_last);
    end
    if (reset_n && in_valid && !in_ready) stall_cnt++;
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input logic [31:0] d, input logic [5:0] len, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_len = len; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL beat_timeout in_ready=%b want 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0; out_ready = 1'b1;
    idle(3);
    total++;
    if ({out_valid, out_last, len_err, out_bytes, fill_bits} !== 14'd0 || out_data !== 64'd0) begin
      bad++;
      $display("FAIL reset_state v=%b l=%b e=%b bytes=%0d fill=%0d data=%h want all zero",
               out_valid, out_last, len_err, out_bytes, fill_bits, out_data);
    end
    reset_n = 1'b1;
    idle(1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want 1", in_ready); end
  endtask

  task automatic test_stream();
    int q0, s0;
    logic [63:0] exp_w [4];
    exp_w = '{64'h3333_2222_1111_0000, 64'h7777_6666_5555_4444,
              64'hBBBB_AAAA_9999_8888, 64'hFFFF_EEEE_DDDD_CCCC};
    q0 = q_data.size(); s0 = stall_cnt; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat({16'hDEAD, {4{4'(i)}}}, 6'd16, 1'b0);
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_latency out_valid=%b want 1", out_valid); end
      end
    end
    idle(3);
    total++;
    if (q_data.size() - q0 != 4) begin bad++; $display("FAIL stream_count got=%0d want 4", q_data.size() - q0); end
    for (int k = 0; k < 4; k++) begin
      if (q_data.size() > q0 + k) begin
        total++;
        if (q_data[q0+k] !== exp_w[k] || q_bytes[q0+k] !== 4'd8 || q_last[q0+k] !== 1'b0) begin
          bad++;
          $display("FAIL stream_word%0d got=%h/%0d/%b want %h/8/0", k, q_data[q0+k], q_bytes[q0+k], q_last[q0+k], exp_w[k]);
        end
      end
    end
    total++;
    if (stall_cnt != s0) begin bad++; $display("FAIL stream_in_ready_low cycles=%0d want 0", stall_cnt - s0); end
    total++;
    if (fill_bits !== 7'd0) begin bad++; $display("FAIL stream_fill got=%0d want 0", fill_bits); end
  endtask

  task automatic test_flush_tail();
    int q0;
    q0 = q_data.size();
    beat(32'hFFFF_FFFF, 6'd30, 1'b0);
    beat(32'h0000_0000, 6'd30, 1'b0);
    beat(32'hFFFF_FFFF, 6'd10, 1'b0);
    total++;
    if (fill_bits !== 7'd6 || out_data !== 64'hF000_0000_3FFF_FFFF) begin
      bad++; $display("FAIL tail_word1 fill=%0d data=%h want 6/f00000003fffffff", fill_bits, out_data);
    end
    beat(32'hFFFF_FFFF, 6'd0, 1'b1);
    idle(3);
    total++;
    if (q_data.size() - q0 != 2) begin
      bad++; $display("FAIL tail_count got=%0d want 2", q_data.size() - q0);
    end else begin
      total++;
      if (q_bytes[q0] !== 4'd8 || q_last[q0] !== 1'b0) begin
        bad++; $display("FAIL tail_first bytes=%0d last=%b want 8/0", q_bytes[q0], q_last[q0]);
      end
      total++;
      if (q_data[q0+1] !== 64'h3F || q_bytes[q0+1] !== 4'd1 || q_last[q0+1] !== 1'b1) begin
        bad++; $display("FAIL tail_flush got=%h/%0d/%b want 3f/1/1", q_data[q0+1], q_bytes[q0+1], q_last[q0+1]);
      end
    end
  endtask

  task automatic test_short_last();
    int q0;
    q0 = q_data.size();
    beat(32'hFFFF_FFFD, 6'd3, 1'b1);
    total++;
    if (fill_bits !== 7'd8) begin bad++; $display("FAIL short_pad fill=%0d want 8", fill_bits); end
    idle(3);
    total++;
    if (q_data.size() - q0 != 1) begin
      bad++; $display("FAIL short_count got=%0d want 1", q_data.size() - q0);
    end else if (q_data[q0] !== 64'h5 || q_bytes[q0] !== 4'd1 || q_last[q0] !== 1'b1) begin
      bad++; $display("FAIL short_word got=%h/%0d/%b want 5/1/1", q_data[q0], q_bytes[q0], q_last[q0]);
    end
  endtask

  task automatic test_empty_block();
    int q0;
    q0 = q_data.size();
    beat(32'hFFFF_FFFF, 6'd0, 1'b1);
    idle(3);
    total++;
    if (q_data.size() - q0 != 1) begin
      bad++; $display("FAIL empty_count got=%0d want 1", q_data.size() - q0);
    end else if (q_data[q0] !== 64'h0 || q_bytes[q0] !== 4'd0 || q_last[q0] !== 1'b1) begin
      bad++; $display("FAIL empty_word got=%h/%0d/%b want 0/0/1", q_data[q0], q_bytes[q0], q_last[q0]);
    end
  endtask

  task automatic test_backpressure();
    int q0;
    q0 = q_data.size();
    out_ready = 1'b0;
    beat(32'h1234_5678, 6'd32, 1'b0);
    beat(32'h9ABC_DEF0, 6'd32, 1'b0);
    beat(32'h0BAD_F00D, 6'd32, 1'b0);
    beat(32'hCAFE_BABE, 6'd32, 1'b0);
    total++;
    if (in_ready !== 1'b0 || fill_bits !== 7'd64 || out_valid !== 1'b1 || out_data !== 64'h9ABC_DEF0_1234_5678) begin
      bad++; $display("FAIL bp_hold rdy=%b fill=%0d v=%b data=%h want 0/64/1/9abcdef012345678",
                      in_ready, fill_bits, out_valid, out_data);
    end
    idle(5);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'h9ABC_DEF0_1234_5678) begin
      bad++; $display("FAIL bp_stable rdy=%b v=%b data=%h want 0/1/9abcdef012345678", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    idle(3);
    total++;
    if (q_data.size() - q0 != 2) begin
      bad++; $display("FAIL bp_count got=%0d want 2", q_data.size() - q0);
    end else if (q_data[q0] !== 64'h9ABC_DEF0_1234_5678 || q_data[q0+1] !== 64'hCAFE_BABE_0BAD_F00D) begin
      bad++; $display("FAIL bp_words got=%h,%h want 9abcdef012345678,cafebabe0badf00d", q_data[q0], q_data[q0+1]);
    end
    total++;
    if (fill_bits !== 7'd0) begin bad++; $display("FAIL bp_fill got=%0d want 0", fill_bits); end
  endtask

  task automatic test_len_err_reset();
    int q0;
    q0 = q_data.size();
    total++;
    if (len_err !== 1'b0) begin bad++; $display("FAIL lenerr_before got=%b want 0", len_err); end
    beat(32'hFFFF_FFFF, 6'd40, 1'b0);
    total++;
    if (len_err !== 1'b1 || fill_bits !== 7'd32) begin
      bad++; $display("FAIL lenerr_clamp err=%b fill=%0d want 1/32", len_err, fill_bits);
    end
    beat(32'h0, 6'd0, 1'b1);
    total++;
    if (in_ready !== 1'b0 || fill_bits !== 7'd32) begin
      bad++; $display("FAIL flush_state rdy=%b fill=%0d want 0/32", in_ready, fill_bits);
    end
    reset_n = 1'b0;
    idle(1);
    total++;
    if (fill_bits !== 7'd0 || out_valid !== 1'b0 || len_err !== 1'b0) begin
      bad++; $display("FAIL flush_reset fill=%0d v=%b err=%b want 0/0/0", fill_bits, out_valid, len_err);
    end
    reset_n = 1'b1;
    idle(1);
    total++;
    if (in_ready !== 1'b1 || q_data.size() != q0) begin
      bad++; $display("FAIL flush_release rdy=%b words=%0d want 1/0", in_ready, q_data.size() - q0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    idle(2);
    test_flush_tail();
    idle(2);
    test_short_last();
    idle(2);
    test_empty_block();
    idle(2);
    test_backpressure();
    idle(2);
    test_len_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
